// File: rtl/piece_fit_engine.sv
// piece_fit_engine
//   Row-serial collision engine for the falling piece. Checks a PIECE_N x
//   PIECE_N mask at a signed board position against the occupancy board and
//   reports legality of the current position and of a one-cell move left,
//   right and down. On a DROP request it then steps the piece down one row
//   per trial pass to find the hard-drop distance.
//
// Ports
//   clk        system clock, all logic on the rising edge
//   reset_n    synchronous active-low reset
//   req_valid  request present; accepted when req_valid & req_ready
//   req_ready  engine idle
//   req_op     0 = CHECK, 1 = DROP
//   piece      mask, bit [r*PIECE_N+c], r=0 top row, c=0 left column
//   board      occupancy, bit [r*BOARD_W+c], row 0 top
//   x, y       signed board position of piece cell (0,0)
//   rsp_valid  result available, held until rsp_ready
//   rsp_ready  consumer takes the result
//   rsp_mask   {C,L,R,D}, 1 = legal
//   rsp_drop   rows the piece can fall (DROP only, else 0)
//
// States
//   state   | meaning
//   IDLE    | waiting for a request, req_ready=1
//   SCAN    | one piece row per cycle for C/L/R/D, then one decision cycle
//   TRIAL   | one piece row per cycle at offset (0,dy), dy = 2,3,...
//   RESP    | result held on rsp_*, waiting for rsp_ready

module piece_fit_engine #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20,
  parameter int PIECE_N = 4,
  parameter int XW      = 5,
  parameter int YW      = 6,
  parameter int DW      = $clog2(BOARD_H + PIECE_N)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_op,
  input  logic [PIECE_N*PIECE_N-1:0]   piece,
  input  logic [BOARD_W*BOARD_H-1:0]   board,
  input  logic signed [XW-1:0]         x,
  input  logic signed [YW-1:0]         y,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [3:0]                   rsp_mask,
  output logic [DW-1:0]                rsp_drop
);

  localparam int AW  = ((XW > YW) ? XW : YW) + 2;
  localparam int CW  = $clog2(PIECE_N + 1);
  localparam int NB  = BOARD_W * BOARD_H;
  localparam int BIW = $clog2(NB);
  localparam int CAP = BOARD_H + PIECE_N - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_TRIAL,
    S_RESP
  } state_t;

  state_t                     state_q, state_n;
  logic                       op_q;
  logic [PIECE_N*PIECE_N-1:0] piece_q;
  logic [NB-1:0]              board_q;
  logic signed [AW-1:0]       x_q, y_q;
  logic [CW-1:0]              cnt_q, cnt_n;
  logic [DW-1:0]              dy_q, dy_n;
  logic                       acc_c_q, acc_l_q, acc_r_q, acc_d_q, acc_t_q;
  logic                       acc_c_n, acc_l_n, acc_r_n, acc_d_n, acc_t_n;
  logic [3:0]                 mask_q, mask_n;
  logic [DW-1:0]              drop_q, drop_n;

  logic                       accept;
  logic                       nonempty;
  logic [PIECE_N-1:0]         prow;
  logic                       row_c, row_l, row_r, row_d, row_t;
  logic                       trial_ok;
  int                         cx0, cy0;

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_mask  = mask_q;
  assign rsp_drop  = drop_q;
  assign accept    = req_valid & req_ready;
  assign nonempty  = |piece_q;

  // Off-board left/right/below is blocked; above the top edge is the spawn
  // zone and counts as free while the column is on the board.
  function automatic logic blocked(input logic [NB-1:0] brd, input int cx, input int cy);
    logic [BIW-1:0] idx;
    idx = '0;
    if (cx < 0 || cx >= BOARD_W || cy >= BOARD_H) return 1'b1;
    if (cy < 0) return 1'b0;
    idx = BIW'(cy * BOARD_W + cx);
    return brd[idx];
  endfunction

  // Evaluate the piece row selected by cnt_q at all offsets. Coordinates are
  // formed in int from the sign-extended registers so nothing wraps.
  always_comb begin
    prow  = '0;
    row_c = 1'b1;
    row_l = 1'b1;
    row_r = 1'b1;
    row_d = 1'b1;
    row_t = 1'b1;
    cx0   = 0;
    cy0   = int'(y_q) + int'(cnt_q);
    for (int r = 0; r < PIECE_N; r++) begin
      if (cnt_q == CW'(r)) prow = piece_q[r*PIECE_N +: PIECE_N];
    end
    for (int c = 0; c < PIECE_N; c++) begin
      cx0 = int'(x_q) + c;
      if (prow[c]) begin
        if (blocked(board_q, cx0,     cy0))                row_c = 1'b0;
        if (blocked(board_q, cx0 - 1, cy0))                row_l = 1'b0;
        if (blocked(board_q, cx0 + 1, cy0))                row_r = 1'b0;
        if (blocked(board_q, cx0,     cy0 + 1))            row_d = 1'b0;
        if (blocked(board_q, cx0,     cy0 + int'(dy_q)))   row_t = 1'b0;
      end
    end
  end

  assign trial_ok = acc_t_q & row_t;

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    dy_n    = dy_q;
    acc_c_n = acc_c_q;
    acc_l_n = acc_l_q;
    acc_r_n = acc_r_q;
    acc_d_n = acc_d_q;
    acc_t_n = acc_t_q;
    mask_n  = mask_q;
    drop_n  = drop_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_n = S_SCAN;
          cnt_n   = '0;
          dy_n    = '0;
          acc_c_n = 1'b1;
          acc_l_n = 1'b1;
          acc_r_n = 1'b1;
          acc_d_n = 1'b1;
          acc_t_n = 1'b1;
        end
      end

      S_SCAN: begin
        if (cnt_q != CW'(PIECE_N)) begin
          acc_c_n = acc_c_q & row_c;
          acc_l_n = acc_l_q & row_l;
          acc_r_n = acc_r_q & row_r;
          acc_d_n = acc_d_q & row_d;
          cnt_n   = cnt_q + CW'(1);
        end else begin
          // Decision cycle: flags are all registered by now.
          mask_n = {acc_c_q, acc_l_q, acc_r_q, acc_d_q};
          drop_n = '0;
          if (op_q && acc_c_q && acc_d_q && nonempty) begin
            state_n = S_TRIAL;
            cnt_n   = '0;
            dy_n    = DW'(2);
            acc_t_n = 1'b1;
          end else begin
            state_n = S_RESP;
          end
        end
      end

      S_TRIAL: begin
        if (cnt_q == CW'(PIECE_N - 1)) begin
          if (!trial_ok || dy_q == DW'(CAP)) begin
            // Reaching the cap reports CAP-1 whether or not that trial passed.
            state_n = S_RESP;
            drop_n  = dy_q - DW'(1);
          end else begin
            dy_n    = dy_q + DW'(1);
            cnt_n   = '0;
            acc_t_n = 1'b1;
          end
        end else begin
          acc_t_n = trial_ok;
          cnt_n   = cnt_q + CW'(1);
        end
      end

      S_RESP: begin
        if (rsp_ready) state_n = S_IDLE;
      end

      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= 1'b0;
      piece_q <= '0;
      board_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      dy_q    <= '0;
      acc_c_q <= 1'b0;
      acc_l_q <= 1'b0;
      acc_r_q <= 1'b0;
      acc_d_q <= 1'b0;
      acc_t_q <= 1'b0;
      mask_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      dy_q    <= dy_n;
      acc_c_q <= acc_c_n;
      acc_l_q <= acc_l_n;
      acc_r_q <= acc_r_n;
      acc_d_q <= acc_d_n;
      acc_t_q <= acc_t_n;
      mask_q  <= mask_n;
      drop_q  <= drop_n;
      if (accept) begin
        op_q    <= req_op;
        piece_q <= piece;
        board_q <= board;
        x_q     <= {{(AW-XW){x[XW-1]}}, x};
        y_q     <= {{(AW-YW){y[YW-1]}}, y};
      end
    end
  end

endmodule

// File: tb/tb_piece_fit_engine.sv
module tb_piece_fit_engine;

  localparam int DW = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_op;
  logic [15:0]   piece_i;
  logic [199:0]  board_i;
  logic signed [4:0] x_i;
  logic signed [5:0] y_i;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [3:0]    rsp_mask;
  logic [DW-1:0] rsp_drop;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_acc = 0;

  typedef struct {
    logic [3:0]    mask;
    logic [DW-1:0] drop;
    int            lat;
  } exp_t;

  exp_t sb[$];

  piece_fit_engine dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .piece     (piece_i),
    .board     (board_i),
    .x         (x_i),
    .y         (y_i),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_mask  (rsp_mask),
    .rsp_drop  (rsp_drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one request, record the accept cycle and push the expected result.
  task automatic issue(input string tag, input logic op, input logic [15:0] pc,
                       input logic [199:0] bd, input logic signed [4:0] xv,
                       input logic signed [5:0] yv, input logic [3:0] em,
                       input logic [DW-1:0] ed, input int el);
    exp_t e;
    @(negedge clk);
    check({tag, " req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    piece_i   = pc;
    board_i   = bd;
    x_i       = xv;
    y_i       = yv;
    @(posedge clk);
    #1;
    t_acc  = cyc;
    e.mask = em;
    e.drop = ed;
    e.lat  = el;
    sb.push_back(e);
    // Scramble inputs: the engine must work from its registered copy.
    req_valid = 1'b0;
    req_op    = ~op;
    piece_i   = 16'hFFFF;
    board_i   = '1;
    x_i       = 5'sd0;
    y_i       = 6'sd0;
  endtask

  // Wait for the response, compare against the scoreboard head, optionally
  // stall rsp_ready for a number of cycles, then release.
  task automatic collect(input string tag, input int hold);
    exp_t e;
    bit got;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    e = sb.pop_front();
    if (!got) begin
      check({tag, " timeout"}, 32'(rsp_valid), 32'd1);
      return;
    end
    check({tag, " latency"}, 32'(cyc - t_acc), 32'(e.lat));
    check({tag, " mask"}, 32'(rsp_mask), 32'(e.mask));
    check({tag, " drop"}, 32'(rsp_drop), 32'(e.drop));
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1;
      @(negedge clk);
      check({tag, " hold valid"}, 32'(rsp_valid), 32'd1);
      check({tag, " hold mask"}, 32'(rsp_mask), 32'(e.mask));
      check({tag, " hold drop"}, 32'(rsp_drop), 32'(e.drop));
      check({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check({tag, " post valid"}, 32'(rsp_valid), 32'd0);
    check({tag, " post req_ready"}, 32'(req_ready), 32'd1);
  endtask

  localparam logic [15:0] O_PC = 16'h0660;  // rows 1-2, cols 1-2
  localparam logic [15:0] I_PC = 16'h00F0;  // row 1, cols 0-3

  initial begin
    logic [199:0] empty_b;
    logic [199:0] b14;
    empty_b = '0;
    b14     = '0;
    b14[14] = 1'b1;  // row 1, col 4

    reset_n   = 1'b0;
    req_valid = 1'b1;  // must be ignored while in reset
    req_op    = 1'b0;
    piece_i   = O_PC;
    board_i   = '0;
    x_i       = 5'sd3;
    y_i       = 6'sd0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_mask", 32'(rsp_mask), 32'd0);
    check("reset rsp_drop", 32'(rsp_drop), 32'd0);
    req_valid = 1'b0;
    reset_n   = 1'b1;
    @(negedge clk);
    check("release req_ready", 32'(req_ready), 32'd1);
    check("release rsp_valid", 32'(rsp_valid), 32'd0);

    // O at x=3 occupies cols 4-5 rows 1-2: everything legal.
    issue("chk_center", 1'b0, O_PC, empty_b, 5'sd3, 6'sd0, 4'b1111, 5'd0, 5);
    collect("chk_center", 0);
    // x=-1 puts the O in cols 0-1: left move hits the wall.
    issue("chk_left", 1'b0, O_PC, empty_b, -5'sd1, 6'sd0, 4'b1011, 5'd0, 5);
    collect("chk_left", 0);
    // x=7 puts the O in cols 8-9: right move hits the wall.
    issue("chk_right", 1'b0, O_PC, empty_b, 5'sd7, 6'sd0, 4'b1101, 5'd0, 5);
    collect("chk_right", 0);
    // y=17 puts the O in rows 18-19: down move hits the floor.
    issue("chk_floor", 1'b0, O_PC, empty_b, 5'sd3, 6'sd17, 4'b1110, 5'd0, 5);
    collect("chk_floor", 0);
    // Hard drop from rows 1-2 to rows 18-19: 17 rows, 17 trial passes.
    issue("drop_o", 1'b1, O_PC, empty_b, 5'sd3, 6'sd0, 4'b1111, 5'd17, 73);
    collect("drop_o", 10);
    // Occupied (row1,col4) blocks C and L (L covers cols 3-4); no trials.
    issue("drop_blk", 1'b1, O_PC, b14, 5'sd3, 6'sd0, 4'b0011, 5'd0, 5);
    collect("drop_blk", 0);
    // Horizontal I in row 0 at x=0: L off-board, falls 19 rows.
    issue("drop_i", 1'b1, I_PC, empty_b, 5'sd0, -6'sd1, 4'b1011, 5'd19, 81);
    collect("drop_i", 0);
    // Empty piece: all legal, no trial passes.
    issue("drop_empty", 1'b1, 16'h0000, b14, 5'sd3, 6'sd0, 4'b1111, 5'd0, 5);
    collect("drop_empty", 0);
    // D illegal on DROP: drop 0 without trials.
    issue("drop_floor", 1'b1, O_PC, empty_b, 5'sd3, 6'sd17, 4'b1110, 5'd0, 5);
    collect("drop_floor", 0);
    // Far above the board: trials run to dy=23 and stop at drop=22.
    issue("drop_cap", 1'b1, O_PC, empty_b, 5'sd3, 6'b100000, 4'b1111, 5'd22, 93);
    collect("drop_cap", 0);

    // Abandon a DROP with a reset in the middle of its trials.
    issue("drop_abort", 1'b1, O_PC, empty_b, 5'sd3, 6'sd0, 4'b1111, 5'd17, 73);
    repeat (20) @(negedge clk);
    reset_n   = 1'b0;
    req_valid = 1'b1;
    req_op    = 1'b0;
    piece_i   = O_PC;
    board_i   = empty_b;
    x_i       = 5'sd3;
    y_i       = 6'sd0;
    @(posedge clk);
    #1;
    check("abort rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    reset_n   = 1'b1;
    sb.delete();
    @(negedge clk);
    check("abort req_ready", 32'(req_ready), 32'd1);
    begin
      bit seen;
      seen = 1'b0;
      repeat (80) begin
        @(negedge clk);
        if (rsp_valid) seen = 1'b1;
      end
      check("abort no response", 32'(seen), 32'd0);
    end

    issue("after_reset", 1'b0, O_PC, empty_b, 5'sd3, 6'sd0, 4'b1111, 5'd0, 5);
    collect("after_reset", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
